// File: rtl/instr_encoder.sv
// Control-bundle to instruction-word encoder with a DEPTH-entry output FIFO.
// Optional error counter enabled by defining INSTR_ENCODER_ERRCNT_EN.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_ctl,
  input  logic [25:0] in_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [5:0] opcode;
  logic       legal;
  logic       accept;
  logic       push;
  logic       pop;

  // Field order: regDst jump branch memRead memtoReg memWrite aluSrc regWrite aluOp
  always_comb begin
    legal  = 1'b1;
    opcode = 6'b000000;
    case (in_ctl)
      11'b1_0_0_0_0_0_0_1_000: opcode = 6'b000000;
      11'b1_0_0_0_0_0_1_1_000: opcode = 6'b000001;
      11'b0_0_0_1_1_0_1_1_011: opcode = 6'b100010;
      11'b0_0_0_0_0_0_1_1_011: opcode = 6'b100011;
      11'b0_0_0_0_0_1_1_0_011: opcode = 6'b101010;
      11'b0_0_1_0_0_0_0_0_100: opcode = 6'b000100;
      11'b0_0_1_0_0_0_0_0_101: opcode = 6'b000110;
      11'b0_1_0_0_0_0_0_0_000: opcode = 6'b010000;
      11'b0_0_0_0_0_0_0_0_000: opcode = 6'b111111;
      default: begin
        legal  = 1'b0;
        opcode = 6'b000000;
      end
    endcase
  end

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = accept && !legal;
    if (push) begin
      mem_d[wr_ptr_q] = {opcode, in_operand};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Gated so stale storage never shows at the head once the FIFO is empty.
  assign out_word = out_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign err      = err_q;

`ifdef INSTR_ENCODER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (accept && !legal && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 8'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, scoreboard queue, corner sequences.
module tb_instr_encoder;

  localparam int DEPTH = 4;
`ifdef INSTR_ENCODER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_ctl;
  logic [25:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        err;
  logic [7:0]  err_count;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl), .in_operand(in_operand),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ctl;
    bit          legal;
    logic [5:0]  opc;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q [$];
  int m_cnt  = 0;
  bit m_err  = 0;
  int m_ecnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_enc(input logic [10:0] c, output logic [5:0] op);
    op = 6'd0;
    for (int i = 0; i < NV; i++)
      if (vec[i].legal && vec[i].ctl == c) begin
        op = vec[i].opc;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic [5:0]  op;
    logic [31:0] exp_w;
    bit acc, leg, pp;
    if (!rst_n) begin
      sb_q.delete();
      m_cnt = 0; m_err = 0; m_ecnt = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_word", out_word, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (m_cnt != DEPTH)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (m_cnt != 0)});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("err_count", {24'd0, err_count}, m_ecnt);
      pp = (m_cnt != 0) && out_ready;
      if (pp) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_empty_scoreboard actual=%h required=none", out_word);
        end else begin
          exp_w = sb_q.pop_front();
          chk("out_word", out_word, exp_w);
        end
      end
      acc = in_valid && (m_cnt != DEPTH);
      leg = ref_enc(in_ctl, op);
      if (acc && leg) sb_q.push_back({op, in_operand});
      m_err = acc && !leg;
      if (CNT_EN && acc && !leg && m_ecnt != 255) m_ecnt++;
      m_cnt = m_cnt + ((acc && leg) ? 1 : 0) - (pp ? 1 : 0);
    end
  end

  task automatic push(input logic [10:0] c, input logic [25:0] o);
    int n = 0;
    in_valid = 1'b1; in_ctl = c; in_operand = o;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout actual=in_ready0 required=in_ready1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] w0;
    vec[0]  = '{11'b1_0_0_0_0_0_0_1_000, 1'b1, 6'b000000};
    vec[1]  = '{11'b1_0_0_0_0_0_1_1_000, 1'b1, 6'b000001};
    vec[2]  = '{11'b0_0_0_1_1_0_1_1_011, 1'b1, 6'b100010};
    vec[3]  = '{11'b0_0_0_0_0_0_1_1_011, 1'b1, 6'b100011};
    vec[4]  = '{11'b0_0_0_0_0_1_1_0_011, 1'b1, 6'b101010};
    vec[5]  = '{11'b0_0_1_0_0_0_0_0_100, 1'b1, 6'b000100};
    vec[6]  = '{11'b0_0_1_0_0_0_0_0_101, 1'b1, 6'b000110};
    vec[7]  = '{11'b0_1_0_0_0_0_0_0_000, 1'b1, 6'b010000};
    vec[8]  = '{11'b0_0_0_0_0_0_0_0_000, 1'b1, 6'b111111};
    vec[9]  = '{11'b1_1_0_0_0_0_0_0_000, 1'b0, 6'b000000};
    vec[10] = '{11'b0_0_0_0_0_0_0_0_001, 1'b0, 6'b000000};
    vec[11] = '{11'b1_0_0_0_0_0_0_1_001, 1'b0, 6'b000000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctl = '0; in_operand = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table pass: legal words appear one cycle after accept; illegal ones pulse err.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      push(vec[i].ctl, 26'h0000ABC);
      if (vec[i].legal) begin
        chk("tbl_valid", {31'd0, out_valid}, 32'd1);
        chk("tbl_word", out_word, {vec[i].opc, 26'h0000ABC});
        chk("tbl_noerr", {31'd0, err}, 32'd0);
      end else begin
        chk("tbl_err", {31'd0, err}, 32'd1);
        if (i == 9) chk("first_err_count", {24'd0, err_count}, CNT_EN ? 32'd1 : 32'd0);
      end
    end
    @(posedge clk); #1;
    chk("err_cleared", {31'd0, err}, 32'd0);
    drain();

    // Fill to full with consumer stalled; fifth bundle waits.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(vec[i].ctl, 26'h100 + 26'(i));
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    w0 = {vec[0].opc, 26'h100};
    in_valid = 1'b1; in_ctl = vec[4].ctl; in_operand = 26'h104;
    repeat (3) begin
      @(posedge clk); #1;
      chk("full_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("full_hold_word", out_word, w0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_pop_ready", {31'd0, in_ready}, 32'd1);
    chk("after_pop_head", out_word, {vec[1].opc, 26'h101});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("refull_ready", {31'd0, in_ready}, 32'd0);
    drain();

    // Random traffic against the scoreboard.
    for (int k = 0; k < 300; k++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_ctl     = vec[$urandom_range(0, NV - 1)].ctl;
      in_operand = 26'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Long illegal stream: counter saturates when built.
    in_valid = 1'b1; in_ctl = vec[9].ctl; in_operand = 26'h0;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("sat_err_count", {24'd0, err_count}, CNT_EN ? 32'd255 : 32'd0);
    chk("sat_err_low", {31'd0, err}, 32'd0);

    // Mid-stream reset with three queued entries.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(vec[5 + i].ctl, 26'h200 + 26'(i));
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_word", out_word, 32'd0);
    chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
